// File: rtl/alu_result_buffer.sv
// alu_result_buffer: capture FIFO behind the combinational ALU.
// Qualified ALU results are normalised and queued, then drained through a
// valid/ready handshake. Also keeps a sticky overflow flag and pulses an
// error when a reserved command is offered.
module alu_result_buffer #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [3:0]                 in_command,
  input  logic [2*SIZE-1:0]          in_result,
  input  logic                       in_overflow,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_command,
  output logic [2*SIZE-1:0]          out_result,
  output logic                       out_overflow,
  output logic                       out_zero,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       sticky_overflow,
  input  logic                       clear_sticky,
  output logic                       err_illegal
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 2 * SIZE;

  logic [3:0]    cmd_mem [DEPTH];
  logic [RW-1:0] res_mem [DEPTH];
  logic          ovf_mem [DEPTH];

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          sticky_q, sticky_d;
  logic          err_q, err_d;

  logic          legal, logic_op, offer, push, pop;
  logic [RW-1:0] norm_res;
  logic          norm_ovf;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);

  assign legal    = (in_command <= 4'h5);
  assign logic_op = (in_command[3:2] == 2'b00);
  assign offer    = in_valid && in_ready;
  assign push     = offer && legal;
  assign pop      = out_valid && out_ready;

  // Logic ops only produce a SIZE-bit result and never overflow.
  assign norm_res = logic_op ? {{SIZE{1'b0}}, in_result[SIZE-1:0]} : in_result;
  assign norm_ovf = logic_op ? 1'b0 : in_overflow;

  // Next-state for FIFO control and status flags.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    err_d    = offer && !legal;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A set in the same cycle as a clear must win.
    if (push && norm_ovf)  sticky_d = 1'b1;
    else if (clear_sticky) sticky_d = 1'b0;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      cmd_mem[tail_q] <= in_command;
      res_mem[tail_q] <= norm_res;
      ovf_mem[tail_q] <= norm_ovf;
    end
  end

  // Head data is forced to zero while the queue is empty.
  always_comb begin
    out_command  = '0;
    out_result   = '0;
    out_overflow = 1'b0;
    out_zero     = 1'b0;
    if (out_valid) begin
      out_command  = cmd_mem[head_q];
      out_result   = res_mem[head_q];
      out_overflow = ovf_mem[head_q];
      out_zero     = (res_mem[head_q] == '0);
    end
  end

  assign count           = count_q;
  assign sticky_overflow = sticky_q;
  assign err_illegal     = err_q;
endmodule
